serial_addsub_digit: RTL and testbench
======================================

# serial_addsub_digit

Digit-serial adder/subtractor with valid/last framing. Operands arrive LSB-digit first, DIGIT_W bits per cycle. Words have arbitrary length up to MAX_DIGITS digits. The block returns registered sum digits plus per-word carry, signed-overflow and framing-error flags. It is the parametrised successor of the bit-serial adder and serves as the arithmetic stage of the sequential-basics datapath.

## Interface
Parameters:
- DIGIT_W, default 4: bits per digit (≥1).
- MAX_DIGITS, default 8: maximum digits per word (≥1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_vld  in  1  input digit valid.
- in_last  in  1  marks the final (most significant) digit of the word; qualified by in_vld.
- sub  in  1  mode: 0 means a+b, 1 means a−b; sampled only on the first digit of a word.
- a  in  DIGIT_W  operand A digit.
- b  in  DIGIT_W  operand B digit.
- out_vld  out  1  output digit valid.
- out_sum  out  DIGIT_W  result digit.
- out_last  out  1  final digit of the result word.
- out_carry  out  1  carry out of the MSB digit; for subtraction, 1 means no borrow.
- out_ovf  out  1  two's-complement overflow of the whole word.
- out_err  out  1  word was force-terminated at MAX_DIGITS.

## Operation
State:
- mid_word: 0 means the next valid digit is a first digit.
- carry (1 bit).
- mode (1 bit).
- cnt: digit counter, width clog2(MAX_DIGITS+1).

Per valid digit:
- First digit (mid_word=0): cin = sub, and mode is loaded with sub. Otherwise cin = carry and mode holds its value.
- b_eff = mode_eff ? ~b : b, where mode_eff = sub on the first digit, else mode.
- full = a + b_eff + cin, computed in DIGIT_W+1 bits. out_sum = full[DIGIT_W−1:0]; carry is loaded with full[DIGIT_W].
- The digit is terminal when in_last=1 or cnt+1 == MAX_DIGITS.
- On a terminal digit:
  - out_last=1 and out_carry=full[DIGIT_W].
  - out_ovf = (a[MSB]==b_eff[MSB]) && (full[DIGIT_W−1]!=a[MSB]).
  - out_err = (in_last==0).
  - mid_word, cnt and carry are cleared.
- On a non-terminal digit: mid_word=1 and cnt increments.
- in_vld=0: no state change. A sub change mid-word is ignored.
- A single-digit word (in_last on the first digit) is legal: it is a plain DIGIT_W-bit add or subtract.
- After out_err, the next valid digit starts a new word. The trailing digits of the over-long word are treated as a fresh word; discarding them is upstream's job.

## Timing
- Latency is 1 cycle: the digit accepted at edge N appears on the outputs after edge N. out_vld follows in_vld delayed by one cycle.
- out_last, out_carry, out_ovf and out_err are 0 in every cycle where out_vld=0.
- out_sum holds its last value while out_vld=0.
- No backpressure: a digit is accepted every cycle in_vld=1. Back-to-back words (a first digit right after a last digit) run at full rate.
- Reset values: every output is 0, and mid_word, carry, mode and cnt are 0.
- Reset asserted mid-word aborts the word with no partial flags. The first valid digit after reset release is a first digit.

## Test plan
Parameters DIGIT_W=4, MAX_DIGITS=8 unless stated. Each digit listed is (a,b), LSB first.

- **Add:** 0x3A+0x29, digits (A,9),(3,2), in_last on the 2nd, sub=0 → out_sum 3 then 6 (0x63); out_last=1, out_carry=0, out_ovf=0 on the 2nd output.
- **Subtract:** 0x10−0x01, digits (0,1),(1,0), sub=1, with sub driven 0 on the 2nd digit → out_sum F then 0 (0x0F); out_carry=1, out_ovf=0.
- **Signed overflow:** 0x7F+0x01, digits (F,1),(7,0) → out_sum 0 then 8; out_carry=0, out_ovf=1. Also 0xFF+0x01 → 0x00, out_carry=1, out_ovf=0.
- **Gaps and back-to-back:** repeat the add with in_vld=0 for 3 cycles between digits → same sums. out_vld is high exactly 2 cycles, each 1 cycle after its input. Then immediately a single-digit sub 5−7 → out_sum E, out_last=1, out_carry=0.
- **Length limit:** 9 digits of (1,1) with no in_last → outputs 1–7 are 2 with out_last=0. Output 8 is 2 with out_last=1 and out_err=1. Output 9 is 2 as the first digit of a new word (cin=0, not a stale carry).
- **Reset mid-word:** accept (F,1) of 0xFF+0x01, assert rst for 2 cycles → all outputs 0. After release, single-digit (1,1) with in_last → out_sum 2, out_carry=0, out_err=0.

Source files
------------

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor: LSB-digit-first operands, one digit per cycle,
// registered result digit with per-word carry, signed-overflow and length-error flags.
module serial_addsub_digit #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic               in_last,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               out_err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic {
    FIRST = 1'b0,
    MID   = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic               carry_reg, carry_next;
  logic               mode_reg, mode_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               mode_eff;
  logic               cin;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   full;
  logic               terminal;
  logic               ovf;

  // The first digit of a word takes its mode and carry-in straight from sub.
  assign mode_eff = (state_reg == MID) ? mode_reg  : sub;
  assign cin      = (state_reg == MID) ? carry_reg : sub;
  assign b_eff    = mode_eff ? ~b : b;
  assign full     = {1'b0, a} + {1'b0, b_eff} + (DIGIT_W + 1)'(cin);
  assign terminal = in_last || (cnt_reg == CNT_W'(MAX_DIGITS - 1));
  assign ovf      = (a[DIGIT_W-1] == b_eff[DIGIT_W-1]) &&
                    (full[DIGIT_W-1] != a[DIGIT_W-1]);

  always_comb begin
    state_next = state_reg;
    carry_next = carry_reg;
    mode_next  = mode_reg;
    cnt_next   = cnt_reg;
    if (in_vld) begin
      mode_next = mode_eff;
      if (terminal) begin
        state_next = FIRST;
        cnt_next   = '0;
        carry_next = 1'b0;
      end else begin
        state_next = MID;
        cnt_next   = cnt_reg + CNT_W'(1);
        carry_next = full[DIGIT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= FIRST;
      carry_reg <= 1'b0;
      mode_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      carry_reg <= carry_next;
      mode_reg  <= mode_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Flags are qualified by in_vld so they are never set on an idle output cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld   <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_vld   <= in_vld;
      out_last  <= in_vld && terminal;
      out_carry <= in_vld && terminal && full[DIGIT_W];
      out_ovf   <= in_vld && terminal && ovf;
      out_err   <= in_vld && terminal && !in_last;
      if (in_vld) begin
        out_sum <= full[DIGIT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Bench for serial_addsub_digit: directed cases plus random digit streams checked
// against a word-level arithmetic reference model.
module tb_serial_addsub_digit;

  localparam int W = 4;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_last = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_vld;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_carry;
  logic         out_ovf;
  logic         out_err;

  int total = 0;
  int bad   = 0;

  // Word-level model: whole operands accumulated so far, summed with plain arithmetic.
  bit           in_word = 1'b0;
  bit           word_sub = 1'b0;
  int           k = 0;
  logic [63:0]  a_acc = '0;
  logic [63:0]  b_acc = '0;
  logic [W-1:0] last_sum = '0;

  serial_addsub_digit #(.DIGIT_W(W), .MAX_DIGITS(M)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_last(in_last), .sub(sub),
    .a(a), .b(b), .out_vld(out_vld), .out_sum(out_sum), .out_last(out_last),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input bit l, input bit s,
                      input logic [W-1:0] da, input logic [W-1:0] db);
    logic [63:0]  tot;
    logic [W-1:0] nb;
    logic [W-1:0] e_sum;
    bit           e_last, e_carry, e_ovf, e_err, term;
    int           nbits;
    e_last = 0; e_carry = 0; e_ovf = 0; e_err = 0;
    in_vld = v; in_last = l; sub = s; a = da; b = db;
    if (v) begin
      if (!in_word) begin
        word_sub = s; k = 0; a_acc = '0; b_acc = '0;
      end
      nb    = word_sub ? ~db : db;
      a_acc = a_acc | (64'(da) << (k * W));
      b_acc = b_acc | (64'(nb) << (k * W));
      tot   = a_acc + b_acc + 64'(word_sub);
      e_sum = tot[k*W +: W];
      term  = l || (k + 1 == M);
      nbits = (k + 1) * W;
      if (term) begin
        e_last  = 1;
        e_carry = tot[nbits];
        e_ovf   = (a_acc[nbits-1] == b_acc[nbits-1]) && (tot[nbits-1] != a_acc[nbits-1]);
        e_err   = !l;
        in_word = 0;
      end else begin
        in_word = 1;
        k++;
      end
      last_sum = e_sum;
    end
    @(posedge clk);
    #1;
    $display("txn vld=%0b last=%0b sub=%0b a=%0h b=%0h -> out_vld=%0b sum=%0h last=%0b c=%0b ovf=%0b err=%0b",
             v, l, s, da, db, out_vld, out_sum, out_last, out_carry, out_ovf, out_err);
    check("out_vld",   32'(out_vld),   32'(v));
    check("out_sum",   32'(out_sum),   32'(last_sum));
    check("out_last",  32'(out_last),  32'(e_last));
    check("out_carry", 32'(out_carry), 32'(e_carry));
    check("out_ovf",   32'(out_ovf),   32'(e_ovf));
    check("out_err",   32'(out_err),   32'(e_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},   32'(out_vld),   32'd0);
    check({tag, "_sum"},   32'(out_sum),   32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_carry"}, 32'(out_carry), 32'd0);
    check({tag, "_ovf"},   32'(out_ovf),   32'd0);
    check({tag, "_err"},   32'(out_err),   32'd0);
  endtask

  task automatic do_reset();
    in_vld = 0;
    rst = 0;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1;
    in_word = 0;
    last_sum = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1;

    // Add 0x3A + 0x29 = 0x63
    step(1, 0, 0, 4'hA, 4'h9);
    check("add_d0", 32'(out_sum), 32'h3);
    step(1, 1, 0, 4'h3, 4'h2);
    check("add_d1", 32'(out_sum), 32'h6);

    // Subtract 0x10 - 0x01, sub dropped on 2nd digit
    step(1, 0, 1, 4'h0, 4'h1);
    step(1, 1, 0, 4'h1, 4'h0);
    check("sub_carry", 32'(out_carry), 32'd1);

    // Signed overflow 0x7F+0x01, then 0xFF+0x01
    step(1, 0, 0, 4'hF, 4'h1);
    step(1, 1, 0, 4'h7, 4'h0);
    check("ovf_7f", 32'(out_ovf), 32'd1);
    step(1, 0, 0, 4'hF, 4'h1);
    step(1, 1, 0, 4'hF, 4'h0);
    check("carry_ff", 32'(out_carry), 32'd1);

    // Gaps with junk on idle inputs, then back-to-back single-digit sub 5-7
    step(1, 0, 0, 4'hA, 4'h9);
    step(0, 1, 1, 4'h5, 4'hC);
    step(0, 0, 1, 4'hF, 4'hF);
    step(0, 1, 0, 4'h1, 4'h7);
    step(1, 1, 1, 4'h3, 4'h2);
    step(1, 1, 1, 4'h5, 4'h7);
    check("single_sub", 32'(out_sum), 32'hE);

    // Length limit: 9 digits with no in_last
    for (int i = 0; i < 9; i++) step(1, 0, 0, 4'h1, 4'h1);
    step(1, 1, 0, 4'h0, 4'h0);

    // Reset mid-word
    step(1, 0, 0, 4'hF, 4'h1);
    do_reset();
    step(1, 1, 0, 4'h1, 4'h1);
    check("post_rst_sum", 32'(out_sum), 32'h2);

    // Random streams
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 1'($urandom),
           W'($urandom), W'($urandom));
    end
    step(0, 0, 0, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
